instr_fetch_queue: RTL

Parametrised fetch stage for the 3-bit-opcode accumulator core. It owns the program counter, reads instruction memory combinationally, and applies static JNZ branch prediction at fetch time. Fetched instructions go into a DEPTH-entry prefetch queue that drives decode through a valid/ready handshake. Execute can flush the queue and redirect the PC on a misprediction.

---
 rtl/instr_fetch_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads imem combinationally and feeds decode through a DEPTH-entry queue.
// Optional feature macro: IF_BRANCH_PREDICT_EN enables static JNZ prediction at fetch time.
module instr_fetch_queue #(
  parameter int unsigned OPC_W    = 3,
  parameter int unsigned OPR_W    = 3,
  parameter int unsigned DATA_W   = 3,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PROG_LEN = 8,
  parameter int unsigned JNZ_OP   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_if,
  input  logic              init_regs,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [OPC_W-1:0]  imem_opcode,
  input  logic [OPR_W-1:0]  imem_operand,
  input  logic              reg_A_wr_en,
  input  logic              reg_A_nz,
  input  logic [DATA_W-1:0] mod_output,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [OPC_W-1:0]  opcode_if_reg,
  output logic [OPR_W-1:0]  operand_if_reg,
  output logic [PC_W-1:0]   pc_if,
  output logic              branch_predicted,
  output logic              fetch_done
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [OPC_W-1:0] opc_mem_q  [DEPTH];
  logic [OPC_W-1:0] opc_mem_d  [DEPTH];
  logic [OPR_W-1:0] opr_mem_q  [DEPTH];
  logic [OPR_W-1:0] opr_mem_d  [DEPTH];
  logic [PC_W-1:0]  pc_mem_q   [DEPTH];
  logic [PC_W-1:0]  pc_mem_d   [DEPTH];
  logic             pred_mem_q [DEPTH];
  logic             pred_mem_d [DEPTH];

  logic             pc_in_prog;
  logic             full;
  logic             pop;
  logic             push;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;

  assign pc_in_prog  = 32'(pc_q) < PROG_LEN;
  assign full        = (count_q == CntW'(DEPTH));
  assign if_valid    = (count_q != '0);
  assign pop         = if_valid && if_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept a push.
  assign push        = !init_regs && !halt_if && !redirect_valid && pc_in_prog && (!full || pop);
  assign pred_target = PC_W'(imem_operand);

`ifdef IF_BRANCH_PREDICT_EN
  // Forward the in-flight A write so the prediction sees the value A is about to hold.
  assign pred_taken = (imem_opcode == OPC_W'(JNZ_OP)) &&
                      (reg_A_wr_en ? (mod_output != '0) : reg_A_nz);
`else
  logic unused_pred_inputs;
  assign unused_pred_inputs = ^{reg_A_wr_en, reg_A_nz, mod_output};
  assign pred_taken         = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    opc_mem_d  = opc_mem_q;
    opr_mem_d  = opr_mem_q;
    pc_mem_d   = pc_mem_q;
    pred_mem_d = pred_mem_q;

    if (init_regs) begin
      pc_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (redirect_valid) begin
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        opc_mem_d[wr_ptr_q]  = imem_opcode;
        opr_mem_d[wr_ptr_q]  = imem_operand;
        pc_mem_d[wr_ptr_q]   = pc_q;
        pred_mem_d[wr_ptr_q] = pred_taken;
        wr_ptr_d             = wr_ptr_q + PtrW'(1);
        pc_d                 = pred_taken ? pred_target : pc_q + PC_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opc_mem_q[i]  <= '0;
        opr_mem_q[i]  <= '0;
        pc_mem_q[i]   <= '0;
        pred_mem_q[i] <= 1'b0;
      end
    end else begin
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      opc_mem_q  <= opc_mem_d;
      opr_mem_q  <= opr_mem_d;
      pc_mem_q   <= pc_mem_d;
      pred_mem_q <= pred_mem_d;
    end
  end

  // Head fields read the slot under the read pointer; meaningless while the queue is empty.
  assign imem_addr        = pc_q;
  assign opcode_if_reg    = opc_mem_q[rd_ptr_q];
  assign operand_if_reg   = opr_mem_q[rd_ptr_q];
  assign pc_if            = pc_mem_q[rd_ptr_q];
  assign branch_predicted = pred_mem_q[rd_ptr_q];
  assign fetch_done       = !pc_in_prog;

endmodule
